// File: rtl/ldl_bus_update_fifo.sv
// Change-detect FIFO: every update of a quasi-static bus (din) is pushed as one entry.
// Overflowing updates are dropped, set a sticky flag and bump a saturating drop counter.
module ldl_bus_update_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [DW-1:0]            din,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    input  logic                     ovf_clr,
    output logic [7:0]               drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DW-1:0] din_q, prev_q;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    drop_q, drop_d;
    logic [DW-1:0] mem_q [DEPTH];

    logic upd, full, pop, wr, drop;

    always_comb begin
        upd  = en && (din_q != prev_q);
        full = (level_q == LW'(DEPTH));
        pop  = (level_q != '0) && out_ready;
        // A full FIFO still takes the update when the head leaves in the same cycle.
        wr   = upd && (!full || pop);
        drop = upd && full && !pop;
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;
        if (wr)  wptr_d = AW'(wptr_q + 1'b1);
        if (pop) rptr_d = AW'(rptr_q + 1'b1);
        if (wr && !pop)      level_d = level_q + 1'b1;
        else if (pop && !wr) level_d = level_q - 1'b1;
        // A drop coinciding with a clear wins: the counter restarts at one.
        if (drop) begin
            ovf_d  = 1'b1;
            if (ovf_clr)              drop_d = 8'd1;
            else if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end else if (ovf_clr) begin
            ovf_d  = 1'b0;
            drop_d = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_q   <= '0;
            prev_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= 8'd0;
        end else begin
            din_q   <= din;
            prev_q  <= din_q;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr) mem_q[wptr_q] <= din_q;
    end

    assign out_valid = (level_q != '0);
    assign out_data  = mem_q[rptr_q];
    assign level     = level_q;
    assign ovf       = ovf_q;
    assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_ldl_bus_update_fifo.sv
// Bench for ldl_bus_update_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ldl_bus_update_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst, en, out_ready, ovf_clr;
    logic [DW-1:0] din;
    logic          out_valid, ovf;
    logic [DW-1:0] out_data;
    logic [$clog2(DEPTH):0] level;
    logic [7:0]    drop_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    ldl_bus_update_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .ovf(ovf), .ovf_clr(ovf_clr), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: din seen one edge late, update = differs from the value before it.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_cur, m_prev;
    bit            m_ovf;
    int            m_drop;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_cur = '0; m_prev = '0; m_ovf = 0; m_drop = 0;
        end else begin
            bit ev, pp, dropped;
            ev = en && (m_cur != m_prev);
            pp = (mq.size() > 0) && out_ready;
            dropped = 0;
            if (pp) void'(mq.pop_front());
            if (ev) begin
                if (mq.size() < DEPTH) mq.push_back(m_cur);
                else dropped = 1;
            end
            if (dropped) begin
                m_ovf  = 1;
                m_drop = ovf_clr ? 1 : (m_drop < 255 ? m_drop + 1 : 255);
            end else if (ovf_clr) begin
                m_ovf = 0; m_drop = 0;
            end
            m_prev = m_cur;
            m_cur  = din;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("model.level", int'(level), mq.size());
            chk("model.out_valid", int'(out_valid), int'(mq.size() > 0));
            if (mq.size() > 0) chk("model.out_data", int'(out_data), int'(mq[0]));
            chk("model.ovf", int'(ovf), int'(m_ovf));
            chk("model.drop_cnt", int'(drop_cnt), m_drop);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; din = '0; out_ready = 1'b1; ovf_clr = 1'b0;
        tick(2);
        chk("rst.level", int'(level), 0);
        chk("rst.out_valid", int'(out_valid), 0);
        chk("rst.ovf", int'(ovf), 0);
        chk("rst.drop_cnt", int'(drop_cnt), 0);
        rst = 1'b0;
        tick();
        chk("zero_din.no_push", int'(out_valid), 0);

        // single update, consumer ready: visible exactly one cycle, two edges after din changes
        din = 8'h05;
        tick();
        chk("lat.edge1_valid", int'(out_valid), 0);
        tick();
        chk("lat.edge2_valid", int'(out_valid), 1);
        chk("lat.edge2_data", int'(out_data), 8'h05);
        tick();
        chk("lat.edge3_valid", int'(out_valid), 0);
        chk("lat.edge3_level", int'(level), 0);

        // six updates into a stalled 4-deep FIFO: 1..4 kept, two dropped
        out_ready = 1'b0;
        for (int v = 1; v <= 6; v++) begin din = DW'(v); tick(); end
        tick(3);
        chk("ovf.level", int'(level), 4);
        chk("ovf.flag", int'(ovf), 1);
        chk("ovf.drop_cnt", int'(drop_cnt), 2);
        chk("ovf.head", int'(out_data), 1);
        out_ready = 1'b1;
        for (int v = 2; v <= 4; v++) begin tick(); chk("drain.data", int'(out_data), v); end
        tick();
        chk("drain.empty", int'(out_valid), 0);

        // full FIFO, update arrives on the same edge as a pop
        out_ready = 1'b0;
        for (int v = 7; v <= 10; v++) begin din = DW'(v); tick(); end
        tick(2);
        chk("fullpop.pre_level", int'(level), 4);
        din = 8'd11;
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("fullpop.level", int'(level), 4);
        chk("fullpop.drop_cnt", int'(drop_cnt), 2);
        chk("fullpop.head", int'(out_data), 8);

        // sticky flag clear, then saturation
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("clr.ovf", int'(ovf), 0);
        chk("clr.drop_cnt", int'(drop_cnt), 0);
        for (int i = 0; i < 302; i++) begin din = (i % 2 == 1) ? 8'hAA : 8'h55; tick(); end
        tick(2);
        chk("sat.drop_cnt", int'(drop_cnt), 255);
        chk("sat.ovf", int'(ovf), 1);
        din = 8'h66; tick();
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("clr_vs_drop.drop_cnt", int'(drop_cnt), 1);
        chk("clr_vs_drop.ovf", int'(ovf), 1);

        out_ready = 1'b1;
        tick(6);
        chk("drain2.level", int'(level), 0);

        // changes while disabled must not fire later
        en = 1'b0;
        din = 8'h10; tick(2);
        din = 8'h20; tick(2);
        en = 1'b1; tick(3);
        chk("en_off.level", int'(level), 0);
        chk("en_off.valid", int'(out_valid), 0);

        // asynchronous reset with three entries queued
        out_ready = 1'b0;
        for (int v = 1; v <= 3; v++) begin din = DW'(v); tick(); end
        tick(2);
        chk("arst.pre_level", int'(level), 3);
        #2 rst = 1'b1;
        #1;
        chk("arst.level", int'(level), 0);
        chk("arst.out_valid", int'(out_valid), 0);
        chk("arst.ovf", int'(ovf), 0);
        chk("arst.drop_cnt", int'(drop_cnt), 0);
        tick(2);
        din = 8'h3C;
        rst = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) din = DW'($urandom_range(0, 3));
            en        = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 2) == 0);
            ovf_clr   = ($urandom_range(0, 39) == 0);
            tick();
        end
        ovf_clr = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ldl_bus_update_fifo.md
LDL_BUS_UPDATE_FIFO -- requirements
Module: LDL_bus_update_fifo

Interface
REQ-001 Parameter DW, default 8: width of the data bus.
REQ-002 Parameter DEPTH, default 4: FIFO entries; the legal set is powers of two from 2 to 16.
REQ-003 clk  input  1: single clock; the same clock as the receive side of the handshake CDC stage feeding din.
REQ-004 rst  input  1: asynchronous, active-high reset.
REQ-005 en  input  1: change-detect enable; 0 blocks new pushes.
REQ-006 din  input  DW: quasi-static bus from the upstream handshake CDC output, synchronous to clk.
REQ-007 out_valid  output  1: FIFO head holds data.
REQ-008 out_ready  input  1: consumer accepts the head when out_valid is 1.
REQ-009 out_data  output  DW: FIFO head value.
REQ-010 level  output  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
REQ-011 ovf  output  1: sticky overflow flag.
REQ-012 ovf_clr  input  1: synchronous clear of ovf and drop_cnt.
REQ-013 drop_cnt  output  8: count of dropped updates, saturating.

Function
REQ-014 The block shall register din every cycle into din_q, and shall copy din_q into prev_q every cycle.
REQ-015 An update event shall occur in a cycle when en=1 and din_q != prev_q.
REQ-016 An update event shall push din_q into the FIFO at the next clock edge.
  - Latency: din changes before edge k; out_data and out_valid are valid after edge k+1 when the FIFO was empty.
REQ-017 A pop shall occur on a clock edge when out_valid=1 and out_ready=1.
  - out_data shall show the next entry after that edge, or out_valid shall drop if the FIFO becomes empty.
REQ-018 out_data shall come from a register or memory read, with no combinational path from din.
  - out_data is don't-care while out_valid=0.
REQ-019 level shall be +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-020 Simultaneous push and pop when level=DEPTH shall accept the push and the pop. No drop occurs.
REQ-021 Simultaneous push and pop when level=0 is impossible, because out_valid=0; the push alone shall take effect.
REQ-022 A push when level=DEPTH with no pop shall handle the drop as follows:
  - discard the new value;
  - set ovf=1;
  - increment drop_cnt, saturating at 255.
  - FIFO contents shall be unchanged.
REQ-023 ovf_clr=1 shall clear ovf and drop_cnt to 0 at the next edge.
  - If ovf_clr=1 coincides with a drop, the drop shall win: ovf=1 and drop_cnt=1.
REQ-024 Read and write pointers shall be $clog2(DEPTH) bits and shall wrap modulo DEPTH. Full and empty shall be derived from level.
REQ-025 Multiple consecutive din changes shall each produce one push. A value that returns to an earlier value shall also push.
REQ-026 en=0 shall suppress pushes but not pops. prev_q shall keep tracking din_q, so no stale event fires when en returns to 1.

Reset
REQ-027 While rst=1, the following shall all hold 0: din_q, prev_q, pointers, level, ovf, drop_cnt, out_valid.
REQ-028 After rst deasserts, a nonzero din shall produce exactly one push, because prev_q resets to 0.
  - A din of 0 shall produce none.
REQ-029 Reset asserted mid-operation shall discard all FIFO contents immediately, without waiting for a clock edge.

Verification
REQ-030 DW=8, DEPTH=4: reset, then din=0x05 held with out_ready=1 -> out_valid=1 with out_data=0x05 two edges after din changes, for one cycle only; level returns to 0.
REQ-031 out_ready=0, din steps 1,2,3,4,5,6 one per cycle -> level=4, FIFO holds 1..4, ovf=1, drop_cnt=2; then out_ready=1 -> data 1,2,3,4 in order, then out_valid=0.
REQ-032 Full FIFO, and a new din change in the same cycle as a pop -> no drop; level stays 4; drop_cnt unchanged.
REQ-033 en=0 while din goes 0x10->0x20, then en=1 with din held -> no push; level=0.
REQ-034 ovf=1 with drop_cnt=2, then ovf_clr pulse -> ovf=0 and drop_cnt=0; 300 forced drops -> drop_cnt=255.
REQ-035 Assert rst asynchronously (off clock edge) with level=3 -> level, out_valid, and ovf read 0 before the next clk edge.
